// File: rtl/vdma_plan_pkg.sv
// Shared types and constants for the frame burst planner: FSM states, MODE
// selectors and the ceil-division datapath width.
package vdma_plan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } plan_state_e;

  localparam logic [31:0] MODE_ONCE = "ONCE";
  localparam logic [31:0] MODE_LINE = "LINE";

  // 65535*65535*24 bits still fits, so frame-level products never truncate
  localparam int CALC_W = 40;

  function automatic logic [CALC_W-1:0] ceil_div(input logic [CALC_W-1:0] num,
                                                 input logic [CALC_W-1:0] den);
    return (num + den - 40'd1) / den;
  endfunction

endpackage

// File: rtl/frame_burst_planner_if.sv
// Burst request / completion handshake between the planner (master) and the
// AXI burst engine (slave).
interface frame_burst_planner_if #(
  parameter int LSIZE = 9
);
  logic             req_valid;
  logic             req_ready;
  logic [LSIZE-1:0] req_len;
  logic             req_eol;
  logic             req_eof;
  logic             burst_done;

  modport master (output req_valid, req_len, req_eol, req_eof,
                  input  req_ready, burst_done);
  modport slave  (input  req_valid, req_len, req_eol, req_eof,
                  output req_ready, burst_done);
endinterface

// File: rtl/beat_calc.sv
// Two-stage beat calculator: stage 1 latches the bit products at load,
// stage 2 ceil-divides them into AXI beats per line and per frame.
module beat_calc
  import vdma_plan_pkg::*;
#(
  parameter int AXI_DSIZE = 256,
  parameter int DSIZE     = 24
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       hactive,
  input  logic [15:0]       vactive,
  output logic [CALC_W-1:0] line_beats,
  output logic [CALC_W-1:0] total_beats
);

  logic [CALC_W-1:0] line_bits_r;
  logic [CALC_W-1:0] frame_bits_r;
  logic [CALC_W-1:0] line_beats_r;
  logic [CALC_W-1:0] total_beats_r;

  // Stage 1: capture bit counts of a line and of the whole frame at load
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      line_bits_r  <= '0;
      frame_bits_r <= '0;
    end else if (load) begin
      line_bits_r  <= CALC_W'(hactive) * CALC_W'(DSIZE);
      frame_bits_r <= CALC_W'(hactive) * CALC_W'(vactive) * CALC_W'(DSIZE);
    end else begin
      line_bits_r  <= line_bits_r;
      frame_bits_r <= frame_bits_r;
    end
  end

  // Stage 2: round bit counts up to whole AXI beats
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      line_beats_r  <= '0;
      total_beats_r <= '0;
    end else begin
      line_beats_r  <= ceil_div(line_bits_r, CALC_W'(AXI_DSIZE));
      total_beats_r <= ceil_div(frame_bits_r, CALC_W'(AXI_DSIZE));
    end
  end

  assign line_beats  = line_beats_r;
  assign total_beats = total_beats_r;

endmodule

// File: rtl/frame_burst_planner.sv
// Splits a video frame into AXI burst requests, per line or as one stream.
// Optional PLANNER_STATS_EN adds burst_cnt / frame_cnt statistics outputs.
module frame_burst_planner
  import vdma_plan_pkg::*;
#(
  parameter int          NOR_BURST_LEN = 200,
  parameter logic [31:0] MODE          = MODE_ONCE,
  parameter int          AXI_DSIZE     = 256,
  parameter int          DSIZE         = 24,
  parameter int          LSIZE         = 9
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [15:0]           vactive,
  input  logic [15:0]           hactive,
  input  logic                  fsync,
  frame_burst_planner_if.master req,
  output logic                  busy,
  output logic                  frame_done
`ifdef PLANNER_STATS_EN
  ,
  output logic [15:0]           burst_cnt,
  output logic [15:0]           frame_cnt
`endif
);

  localparam bit                LINE_MODE = (MODE == MODE_LINE);
  localparam logic [CALC_W-1:0] NOR_LEN   = CALC_W'(NOR_BURST_LEN);

  if (!((NOR_BURST_LEN < (32'd1 << LSIZE)) &&
        (((AXI_DSIZE % DSIZE) == 0) || (AXI_DSIZE > DSIZE)))) begin : g_param_chk
    $error("frame_burst_planner: illegal NOR_BURST_LEN/LSIZE/AXI_DSIZE/DSIZE");
  end

  plan_state_e       state_r, next_state_s;
  logic              calc_cnt_r;
  logic [15:0]       vactive_r;
  logic [15:0]       line_r, line_nxt_s;
  logic [CALC_W-1:0] rem_r, rem_nxt_s, len_s;
  logic [CALC_W-1:0] line_beats_s, total_beats_s;
  logic              eol_s, eof_s, accept_s;
  logic              req_valid_r, req_eol_r, req_eof_r, busy_r, frame_done_r;
  logic [LSIZE-1:0]  req_len_r;

  beat_calc #(.AXI_DSIZE(AXI_DSIZE), .DSIZE(DSIZE)) u_beat_calc (
    .clock       (clock),
    .rst         (rst),
    .load        (fsync),
    .hactive     (hactive),
    .vactive     (vactive),
    .line_beats  (line_beats_s),
    .total_beats (total_beats_s)
  );

  assign accept_s = (state_r == ST_ISSUE) && req.req_ready && !fsync;

  // Next state plus the remaining-beat / line bookkeeping for the next request
  always_comb begin
    next_state_s = state_r;
    rem_nxt_s    = rem_r;
    line_nxt_s   = line_r;
    if (fsync) begin
      next_state_s = ST_CALC;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = ST_IDLE;
        ST_CALC: begin
          if (calc_cnt_r) begin
            line_nxt_s = 16'd0;
            if ((line_beats_s == '0) || (vactive_r == 16'd0)) begin
              next_state_s = ST_DONE;
              rem_nxt_s    = '0;
            end else begin
              next_state_s = ST_ISSUE;
              rem_nxt_s    = LINE_MODE ? line_beats_s : total_beats_s;
            end
          end else begin
            next_state_s = ST_CALC;
          end
        end
        ST_ISSUE: begin
          if (req.req_ready) begin
            next_state_s = ST_WAIT;
            // a finished line that is not the last one reloads a fresh line
            if (LINE_MODE && req_eol_r && !req_eof_r) begin
              rem_nxt_s  = line_beats_s;
              line_nxt_s = line_r + 16'd1;
            end else begin
              rem_nxt_s  = rem_r - CALC_W'(req_len_r);
            end
          end else begin
            next_state_s = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (req.burst_done) begin
            next_state_s = (rem_r != '0) ? ST_ISSUE : ST_DONE;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        ST_DONE: next_state_s = ST_IDLE;
        default: next_state_s = ST_IDLE;
      endcase
    end
    len_s = (rem_nxt_s < NOR_LEN) ? rem_nxt_s : NOR_LEN;
    eol_s = (rem_nxt_s <= NOR_LEN);
    eof_s = eol_s && (!LINE_MODE || (line_nxt_s == (vactive_r - 16'd1)));
  end

  // State, counters and registered request outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      calc_cnt_r   <= 1'b0;
      vactive_r    <= 16'd0;
      line_r       <= 16'd0;
      rem_r        <= '0;
      req_valid_r  <= 1'b0;
      req_len_r    <= '0;
      req_eol_r    <= 1'b0;
      req_eof_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      calc_cnt_r   <= (state_r == ST_CALC) && !fsync;
      vactive_r    <= fsync ? vactive : vactive_r;
      line_r       <= line_nxt_s;
      rem_r        <= rem_nxt_s;
      req_valid_r  <= (next_state_s == ST_ISSUE);
      if (next_state_s == ST_ISSUE) begin
        req_len_r <= LSIZE'(len_s);
        req_eol_r <= eol_s;
        req_eof_r <= eof_s;
      end else begin
        req_len_r <= '0;
        req_eol_r <= 1'b0;
        req_eof_r <= 1'b0;
      end
      busy_r       <= (next_state_s != ST_IDLE);
      frame_done_r <= (state_r == ST_DONE);
    end
  end

  assign req.req_valid = req_valid_r;
  assign req.req_len   = req_len_r;
  assign req.req_eol   = req_eol_r;
  assign req.req_eof   = req_eof_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;

`ifdef PLANNER_STATS_EN
  logic [15:0] burst_cnt_r;
  logic [15:0] frame_cnt_r;

  // Per-frame accepted bursts and free-running completed-frame count
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      burst_cnt_r <= 16'd0;
      frame_cnt_r <= 16'd0;
    end else begin
      if (fsync) begin
        burst_cnt_r <= 16'd0;
      end else if (accept_s) begin
        burst_cnt_r <= burst_cnt_r + 16'd1;
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
      frame_cnt_r <= frame_done_r ? (frame_cnt_r + 16'd1) : frame_cnt_r;
    end
  end

  assign burst_cnt = burst_cnt_r;
  assign frame_cnt = frame_cnt_r;
`else
  logic unused_s;
  assign unused_s = accept_s;
`endif

endmodule

// File: tb/tb_frame_burst_planner.sv
// Self-checking bench: one ONCE-mode and one LINE-mode planner driven by
// directed and random frames, compared against a burst-list reference model.
module tb_frame_burst_planner;

  localparam int NOR  = 200;
  localparam int DSZ  = 24;
  localparam int ADSZ = 256;

  typedef struct {
    int len;
    bit eol;
    bit eof;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hactive = 16'd0;
  logic [15:0] vactive = 16'd0;
  logic        fsync_o = 1'b0, fsync_l = 1'b0;
  logic        busy_o, busy_l, fdone_o, fdone_l;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          fd_o = 0, fd_l = 0;
  burst_t      exp_q[$];

  frame_burst_planner_if #(.LSIZE(9)) if_o ();
  frame_burst_planner_if #(.LSIZE(9)) if_l ();

`ifdef PLANNER_STATS_EN
  logic [15:0] bcnt_o, fcnt_o, bcnt_l, fcnt_l;
`endif

  frame_burst_planner #(.MODE("ONCE")) dut_o (
    .clock(clk), .rst(rst), .vactive(vactive), .hactive(hactive), .fsync(fsync_o),
    .req(if_o), .busy(busy_o), .frame_done(fdone_o)
`ifdef PLANNER_STATS_EN
    , .burst_cnt(bcnt_o), .frame_cnt(fcnt_o)
`endif
  );

  frame_burst_planner #(.MODE("LINE")) dut_l (
    .clock(clk), .rst(rst), .vactive(vactive), .hactive(hactive), .fsync(fsync_l),
    .req(if_l), .busy(busy_l), .frame_done(fdone_l)
`ifdef PLANNER_STATS_EN
    , .burst_cnt(bcnt_l), .frame_cnt(fcnt_l)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fdone_o === 1'b1) fd_o++;
    if (fdone_l === 1'b1) fd_l++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic logic o_valid(input bit m);
    return m ? if_l.req_valid : if_o.req_valid;
  endfunction
  function automatic logic [8:0] o_len(input bit m);
    return m ? if_l.req_len : if_o.req_len;
  endfunction
  function automatic logic o_eol(input bit m);
    return m ? if_l.req_eol : if_o.req_eol;
  endfunction
  function automatic logic o_eof(input bit m);
    return m ? if_l.req_eof : if_o.req_eof;
  endfunction
  function automatic logic o_busy(input bit m);
    return m ? busy_l : busy_o;
  endfunction
  function automatic int o_fd(input bit m);
    return m ? fd_l : fd_o;
  endfunction

  task automatic set_ready(input bit m, input logic v);
    if (m) if_l.req_ready = v; else if_o.req_ready = v;
  endtask
  task automatic set_done(input bit m, input logic v);
    if (m) if_l.burst_done = v; else if_o.burst_done = v;
  endtask
  task automatic set_fsync(input bit m, input logic v);
    if (m) fsync_l = v; else fsync_o = v;
  endtask

  // Reference: chop each unit (frame or line) into NOR-sized chunks
  function automatic void build_plan(input bit line_mode, input int h, input int v);
    longint rem;
    burst_t b;
    exp_q.delete();
    if (h == 0 || v == 0) return;
    for (int l = 0; l < (line_mode ? v : 1); l++) begin
      rem = line_mode ? (longint'(h) * DSZ + ADSZ - 1) / ADSZ
                      : (longint'(h) * v * DSZ + ADSZ - 1) / ADSZ;
      while (rem > 0) begin
        b.len = (rem > NOR) ? NOR : int'(rem);
        rem  -= b.len;
        b.eol = (rem == 0);
        b.eof = (rem == 0) && (!line_mode || l == v - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic start_frame(input bit m, input int h, input int v);
    hactive = 16'(h);
    vactive = 16'(v);
    build_plan(m, h, v);
    set_fsync(m, 1'b1);
    step();
    set_fsync(m, 1'b0);
  endtask

  task automatic serve_one(input bit m, input int i, input int stall);
    int n = 0;
    while (o_valid(m) !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("valid[%0d]", i), 64'(o_valid(m)), 64'd1);
    chk($sformatf("len[%0d]", i), 64'(o_len(m)), 64'(exp_q[i].len));
    chk($sformatf("eol[%0d]", i), 64'(o_eol(m)), 64'(exp_q[i].eol));
    chk($sformatf("eof[%0d]", i), 64'(o_eof(m)), 64'(exp_q[i].eof));
    chk($sformatf("busy[%0d]", i), 64'(o_busy(m)), 64'd1);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", 64'(o_valid(m)), 64'd1);
      chk("stall_len", 64'(o_len(m)), 64'(exp_q[i].len));
      chk("stall_flags", 64'({o_eol(m), o_eof(m)}), 64'({exp_q[i].eol, exp_q[i].eof}));
    end
    set_ready(m, 1'b1);
    step();
    set_ready(m, 1'b0);
    chk("valid_low_wait", 64'(o_valid(m)), 64'd0);
  endtask

  task automatic serve_frame(input bit m, input int stall);
    for (int i = 0; i < exp_q.size(); i++) begin
      serve_one(m, i, (stall >= 0) ? stall : int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) step();
      set_done(m, 1'b1);
      step();
      set_done(m, 1'b0);
    end
  endtask

  task automatic finish_frame(input bit m, input int fd_before);
    repeat (6) step();
    chk("frame_done_count", 64'(o_fd(m)), 64'(fd_before + 1));
    chk("idle_busy", 64'(o_busy(m)), 64'd0);
  endtask

  initial begin
    int fd0, h, v;
    bit m;
    if_o.req_ready = 1'b0; if_o.burst_done = 1'b0;
    if_l.req_ready = 1'b0; if_l.burst_done = 1'b0;

    // reset state
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      m = 1'(k);
      chk("rst_valid", 64'(o_valid(m)), 64'd0);
      chk("rst_len", 64'(o_len(m)), 64'd0);
      chk("rst_flags", 64'({o_eol(m), o_eof(m)}), 64'd0);
      chk("rst_busy", 64'(o_busy(m)), 64'd0);
    end
    chk("rst_fdone", 64'({fdone_o, fdone_l}), 64'd0);
    rst = 1'b0;

    // idle ignores ready/burst_done
    set_ready(1'b0, 1'b1); set_done(1'b0, 1'b1);
    set_ready(1'b1, 1'b1); set_done(1'b1, 1'b1);
    repeat (4) step();
    set_ready(1'b0, 1'b0); set_done(1'b0, 1'b0);
    set_ready(1'b1, 1'b0); set_done(1'b1, 1'b0);
    chk("idle_ignore_busy", 64'({busy_o, busy_l}), 64'd0);
    chk("idle_ignore_valid", 64'({if_o.req_valid, if_l.req_valid}), 64'd0);
    chk("idle_ignore_fd", 64'(fd_o + fd_l), 64'd0);

    // ONCE 1920x2 -> 200,160
    fd0 = fd_o;
    start_frame(1'b0, 1920, 2);
    serve_frame(1'b0, 0);
    finish_frame(1'b0, fd0);
`ifdef PLANNER_STATS_EN
    chk("stats_burst_cnt", 64'(bcnt_o), 64'd2);
    chk("stats_frame_cnt", 64'(fcnt_o), 64'd1);
`endif

    // LINE 1920x3 -> 3x180
    fd0 = fd_l;
    start_frame(1'b1, 1920, 3);
    serve_frame(1'b1, 0);
    finish_frame(1'b1, fd0);

    // LINE 100x1 -> single 10-beat burst
    fd0 = fd_l;
    start_frame(1'b1, 100, 1);
    serve_frame(1'b1, 1);
    finish_frame(1'b1, fd0);

    // hactive=0: no request, frame_done 4 cycles after fsync
    fd0 = fd_o;
    start_frame(1'b0, 0, 5);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("zero_fdone_c%0d", c), 64'(fdone_o), 64'(c == 4));
      chk("zero_valid", 64'(if_o.req_valid), 64'd0);
      if (c < 5) step();
    end
    finish_frame(1'b0, fd0);

    // vactive=0 in LINE mode
    fd0 = fd_l;
    start_frame(1'b1, 640, 0);
    serve_frame(1'b1, 0);
    finish_frame(1'b1, fd0);

    // ready stalled 5 cycles
    fd0 = fd_o;
    start_frame(1'b0, 1920, 2);
    serve_frame(1'b0, 5);
    finish_frame(1'b0, fd0);

    // abort in WAIT with simultaneous burst_done
    fd0 = fd_o;
    start_frame(1'b0, 1920, 2);
    serve_one(1'b0, 0, 0);
    hactive = 16'd640;
    vactive = 16'd4;
    build_plan(1'b0, 640, 4);
    fsync_o = 1'b1;
    if_o.burst_done = 1'b1;
    step();
    fsync_o = 1'b0;
    if_o.burst_done = 1'b0;
    chk("abort_valid", 64'(if_o.req_valid), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd1);
    serve_frame(1'b0, -1);
    finish_frame(1'b0, fd0);

    // random frames
    for (int r = 0; r < 10; r++) begin
      m = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4000));
      v = int'($urandom_range(0, 6));
      fd0 = o_fd(m);
      start_frame(m, h, v);
      serve_frame(m, -1);
      finish_frame(m, fd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_burst_planner.md
FRAME_BURST_PLANNER -- requirements
Module: frame_burst_planner

Interface
REQ-001 SHALL have parameter NOR_BURST_LEN, default 200, normal burst length in AXI beats.
REQ-002 SHALL have parameter MODE, default "ONCE": "ONCE" plans the frame as one stream; "LINE" plans each line separately.
REQ-003 SHALL have parameter AXI_DSIZE, default 256, AXI data width in bits.
REQ-004 SHALL have parameter DSIZE, default 24, pixel width in bits.
REQ-005 SHALL have parameter LSIZE, default 9, burst-length field width.
REQ-006 SHALL have port clock, input, 1, the single clock of the block.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports vactive and hactive, input, 16 each, frame lines and pixels per line, sampled at fsync.
REQ-009 SHALL have port fsync, input, 1, one-cycle frame start pulse.
REQ-010 SHALL have ports req_valid (output, 1), req_ready (input, 1) and req_len (output, LSIZE), the burst request handshake and its length in beats.
REQ-011 SHALL have ports req_eol and req_eof, output, 1 each, marking the last burst of a line and of the frame.
REQ-012 SHALL have port burst_done, input, 1, pulse on completion of the accepted burst.
REQ-013 SHALL have ports busy and frame_done, output, 1 each; frame_done is a one-cycle pulse.

Function
REQ-014 SHALL compute line_beats = ceil(hactive*DSIZE/AXI_DSIZE) and, in ONCE mode, total_beats = ceil(hactive*vactive*DSIZE/AXI_DSIZE), using 40-bit intermediates without truncation.
REQ-015 SHALL implement states IDLE, CALC, ISSUE, WAIT, DONE.
REQ-016 Transitions SHALL be:
- IDLE->CALC on fsync.
- CALC->ISSUE after exactly 2 cycles.
- ISSUE->WAIT on req_valid&&req_ready.
- WAIT->ISSUE on burst_done with beats remaining.
- WAIT->DONE on burst_done with none remaining.
- DONE->IDLE after 1 cycle.
REQ-017 In ISSUE, req_len SHALL be min(NOR_BURST_LEN, remaining beats of the current unit); the unit is the line in LINE mode and the frame in ONCE mode.
REQ-018 req_valid, req_len, req_eol and req_eof SHALL be held stable from assertion until accepted.
REQ-019 At most one burst SHALL be outstanding; req_valid SHALL be low in WAIT.
REQ-020 In LINE mode, a line counter SHALL advance and reload line_beats after each eol burst; req_eof SHALL be set on the eol burst of line vactive-1.
REQ-021 In ONCE mode, req_eol SHALL equal req_eof.
REQ-022 frame_done SHALL pulse in DONE.
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 If hactive==0 or vactive==0, the block SHALL go CALC->DONE with no request.
REQ-025 fsync in any non-IDLE state SHALL abort the current frame, deassert req_valid, discard pending burst_done, and re-enter CALC with the new sizes; fsync SHALL win over a simultaneous burst_done.
REQ-026 burst_done outside WAIT SHALL be ignored.

Reset
REQ-027 On rst the block SHALL enter IDLE, with req_valid, req_eol, req_eof, busy and frame_done all 0, req_len 0, and all counters cleared, asynchronously.
REQ-028 After rst deasserts, the block SHALL ignore everything except fsync.

Configuration
REQ-029 With PLANNER_STATS_EN defined, the block SHALL add output burst_cnt (16 bits, bursts accepted this frame, cleared at fsync) and output frame_cnt (16 bits, frame_done pulses, wrapping at 0xFFFF->0).
REQ-030 Without PLANNER_STATS_EN, neither port nor its logic SHALL exist.

Structure
REQ-031 The state enum, the MODE string constants and the ceil-division width constants SHALL live in package vdma_plan_pkg.
REQ-032 The beat calculation SHALL be the sub-module beat_calc: a 2-stage registered multiply and ceil-divide.
REQ-033 The block SHALL elaborate-time assert NOR_BURST_LEN < 2**LSIZE and AXI_DSIZE % DSIZE == 0 or AXI_DSIZE > DSIZE.

Verification
REQ-034 The bench SHALL cover: ONCE mode, hactive=1920, vactive=2 (360 beats) -> bursts 200, 160; eol=eof=1 on the second; one frame_done.
REQ-035 The bench SHALL cover: LINE mode, hactive=1920, vactive=3 -> three bursts of 180, each eol=1, eof=1 only on the third.
REQ-036 The bench SHALL cover: LINE mode, hactive=100 (10 beats), vactive=1 -> a single burst of 10 with eol=eof=1.
REQ-037 The bench SHALL cover: hactive=0 -> no req_valid, frame_done exactly 4 cycles after fsync.
REQ-038 The bench SHALL cover: fsync asserted in WAIT together with burst_done -> the old frame is abandoned, the new frame plans from the start, and no spurious frame_done occurs.
REQ-039 The bench SHALL cover: req_ready held low for 5 cycles -> req_len and flags stay stable; with PLANNER_STATS_EN, burst_cnt = 2 after the first scenario.
